// File: rtl/rf_access_arbiter_pkg.sv
// Shared definitions for the register-file access arbiter.
package rf_access_arbiter_pkg;

    // Default number of ACCESS cycles to wait for rf_access_complete.
    localparam int unsigned TIMEOUT_DEFAULT = 15;

    // Width of the saturating timeout event counter.
    localparam int unsigned TCOUNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rf_access_arbiter_if.sv
// Requester and register-file bus bundle for rf_access_arbiter.
// slave: the arbiter's view; master: requesters plus register file.
interface rf_access_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
);
    logic              req0_valid;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_address;
    logic [DATA_W-1:0] req0_write_data;
    logic              req0_done;
    logic [DATA_W-1:0] req0_read_data;
    logic              req0_error;

    logic              req1_valid;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_address;
    logic [DATA_W-1:0] req1_write_data;
    logic              req1_done;
    logic [DATA_W-1:0] req1_read_data;
    logic              req1_error;

    logic [ADDR_W-1:0] rf_address;
    logic              rf_read_en;
    logic              rf_write_en;
    logic [DATA_W-1:0] rf_write_data;
    logic [DATA_W-1:0] rf_read_data;
    logic              rf_access_complete;
    logic              rf_invalid_address;

    modport slave (
        input  req0_valid, req0_write, req0_address, req0_write_data,
        output req0_done, req0_read_data, req0_error,
        input  req1_valid, req1_write, req1_address, req1_write_data,
        output req1_done, req1_read_data, req1_error,
        output rf_address, rf_read_en, rf_write_en, rf_write_data,
        input  rf_read_data, rf_access_complete, rf_invalid_address
    );

    modport master (
        output req0_valid, req0_write, req0_address, req0_write_data,
        input  req0_done, req0_read_data, req0_error,
        output req1_valid, req1_write, req1_address, req1_write_data,
        input  req1_done, req1_read_data, req1_error,
        input  rf_address, rf_read_en, rf_write_en, rf_write_data,
        output rf_read_data, rf_access_complete, rf_invalid_address
    );

endinterface

// File: rtl/rf_access_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       res_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // 1 = req1 is favoured on the next tie; reset favours req0.
    logic prio1;

    // One-hot grant from the current requests and tie-break pointer.
    always_comb begin
        grant = '0;
        if (req[0] && req[1]) begin
            grant = prio1 ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

    // Move the pointer away from whoever was just granted.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            prio1 <= 1'b0;
        end else if (accept && (grant != 2'b00)) begin
            prio1 <= grant[0];
        end
    end

endmodule

// File: rtl/rf_access_arbiter.sv
// Two-requester register-file access arbiter with timeout and error return.
module rf_access_arbiter
    import rf_access_arbiter_pkg::*;
#(
    parameter int          ADDR_W  = 5,
    parameter int          DATA_W  = 64,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                res_n,
    rf_access_arbiter_if.slave  bus,
    output logic [TCOUNT_W-1:0] timeout_count
);

    state_t              state;
    logic                winner;
    logic                is_write;
    logic [7:0]          access_cnt;
    logic [1:0]          grant;
    logic                accept;

    logic                sel_write;
    logic [ADDR_W-1:0]   sel_address;
    logic [DATA_W-1:0]   sel_write_data;

    logic                resp_fire;
    logic                resp_error;
    logic [DATA_W-1:0]   resp_data;

    logic [ADDR_W-1:0]   rf_address;
    logic                rf_read_en;
    logic                rf_write_en;
    logic [DATA_W-1:0]   rf_write_data;
    logic                req0_done;
    logic                req1_done;
    logic                req0_error;
    logic                req1_error;
    logic [DATA_W-1:0]   req0_read_data;
    logic [DATA_W-1:0]   req1_read_data;

    assign accept = (state == ST_IDLE);

    rr_arbiter2 u_rr (
        .clk    (clk),
        .res_n  (res_n),
        .req    ({bus.req1_valid, bus.req0_valid}),
        .accept (accept),
        .grant  (grant)
    );

    // Mux the granted requester's fields ahead of the latch.
    always_comb begin
        sel_write      = grant[1] ? bus.req1_write      : bus.req0_write;
        sel_address    = grant[1] ? bus.req1_address    : bus.req0_address;
        sel_write_data = grant[1] ? bus.req1_write_data : bus.req0_write_data;
    end

    // Decide whether this ACCESS cycle ends the access, and with what result.
    always_comb begin
        resp_fire  = 1'b0;
        resp_error = 1'b0;
        resp_data  = '0;
        if (state == ST_ACCESS) begin
            if (bus.rf_access_complete) begin
                resp_fire  = 1'b1;
                resp_error = bus.rf_invalid_address;
                resp_data  = is_write ? '0 : bus.rf_read_data;
            end else if (access_cnt == 8'(TIMEOUT)) begin
                resp_fire  = 1'b1;
                resp_error = 1'b1;
            end
        end
    end

    // Main FSM; strobes and response pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state          <= ST_IDLE;
            winner         <= 1'b0;
            is_write       <= 1'b0;
            access_cnt     <= '0;
            rf_address     <= '0;
            rf_write_data  <= '0;
            rf_read_en     <= 1'b0;
            rf_write_en    <= 1'b0;
            req0_done      <= 1'b0;
            req1_done      <= 1'b0;
            req0_error     <= 1'b0;
            req1_error     <= 1'b0;
            req0_read_data <= '0;
            req1_read_data <= '0;
            timeout_count  <= '0;
        end else begin
            rf_read_en     <= 1'b0;
            rf_write_en    <= 1'b0;
            req0_done      <= 1'b0;
            req1_done      <= 1'b0;
            req0_error     <= 1'b0;
            req1_error     <= 1'b0;
            req0_read_data <= '0;
            req1_read_data <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        winner        <= grant[1];
                        is_write      <= sel_write;
                        rf_address    <= sel_address;
                        rf_write_data <= sel_write_data;
                        rf_write_en   <= sel_write;
                        rf_read_en    <= !sel_write;
                        access_cnt    <= 8'd1;
                        state         <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (resp_fire) begin
                        if (winner) begin
                            req1_done      <= 1'b1;
                            req1_error     <= resp_error;
                            req1_read_data <= resp_data;
                        end else begin
                            req0_done      <= 1'b1;
                            req0_error     <= resp_error;
                            req0_read_data <= resp_data;
                        end
                        if (!bus.rf_access_complete && (timeout_count != '1)) begin
                            timeout_count <= timeout_count + 1'b1;
                        end
                        state <= ST_RESP;
                    end else begin
                        access_cnt <= access_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rf_address     = rf_address;
    assign bus.rf_read_en     = rf_read_en;
    assign bus.rf_write_en    = rf_write_en;
    assign bus.rf_write_data  = rf_write_data;
    assign bus.req0_done      = req0_done;
    assign bus.req1_done      = req1_done;
    assign bus.req0_error     = req0_error;
    assign bus.req1_error     = req1_error;
    assign bus.req0_read_data = req0_read_data;
    assign bus.req1_read_data = req1_read_data;

endmodule

// File: doc/rf_access_arbiter.md
RF_ACCESS_ARBITER -- requirements
Module: rf_access_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, width of the register-file address.
REQ-002 Parameter DATA_W, default 64, width of the read and write data.
REQ-003 Parameter TIMEOUT, default 15, maximum ACCESS cycles to wait for rf_access_complete; legal range 1..255.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 res_n  input  1  reset, synchronous, active-low.
REQ-006 reqN_valid  input  1  requester N (N=0,1) has a pending access; held high until reqN_done.
REQ-007 reqN_write  input  1  1 = write access, 0 = read access.
REQ-008 reqN_address  input  ADDR_W  target register address.
REQ-009 reqN_write_data  input  DATA_W  write payload.
REQ-010 reqN_done  output  1  one-cycle completion pulse to requester N.
REQ-011 reqN_read_data  output  DATA_W  read result; valid while reqN_done=1.
REQ-012 reqN_error  output  1  invalid address or timeout; valid while reqN_done=1.
REQ-013 rf_address  output  ADDR_W  address to the register file.
REQ-014 rf_read_en  output  1  read strobe to the register file.
REQ-015 rf_write_en  output  1  write strobe to the register file.
REQ-016 rf_write_data  output  DATA_W  write data to the register file.
REQ-017 rf_read_data  input  DATA_W  register-file read data.
REQ-018 rf_access_complete  input  1  register file has finished the access.
REQ-019 rf_invalid_address  input  1  register file rejected the address.
REQ-020 timeout_count  output  8  saturating count of timed-out accesses.

Function
REQ-021 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-022 IDLE, at the edge when any reqN_valid=1: select a winner, latch its address, data and write flag into rf_address/rf_write_data, set exactly one of rf_read_en/rf_write_en, go to ACCESS.
REQ-023 Arbitration SHALL be round-robin: on simultaneous valid, grant the requester not granted last; after reset req0 has priority.
REQ-024 The rf strobe SHALL be high for exactly the first ACCESS cycle; rf_address/rf_write_data SHALL stay stable through ACCESS and RESP.
REQ-025 ACCESS SHALL sample rf_access_complete every cycle, including the strobe cycle; when it is 1, capture rf_read_data (reads only, else 0) and rf_invalid_address into the winner's response registers, then go to RESP.
REQ-026 An ACCESS cycle counter SHALL start at 1; if TIMEOUT cycles elapse without complete, go to RESP with error=1, read_data=0, and increment timeout_count (saturating at 255).
REQ-027 RESP SHALL pulse the winner's reqN_done for one cycle with reqN_error/reqN_read_data, then return to IDLE; the loser's outputs SHALL stay 0.
REQ-028 Latency: valid sampled at edge T -> strobe in cycle T+1 -> earliest done in cycle T+2; minimum one IDLE cycle between transactions.
REQ-029 reqN_valid deasserting mid-transaction SHALL be ignored; the access completes and done still pulses.
REQ-030 rf_access_complete while in IDLE or RESP SHALL be ignored.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 When res_n=0 at an edge: state IDLE, all strobes, done, error, data and address outputs 0, timeout_count 0, round-robin pointer to req0; an in-flight access is abandoned with no done pulse.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding and the default TIMEOUT constant.
REQ-034 The round-robin grant logic SHALL be a sub-module, rr_arbiter2.

Verification
REQ-035 req0 writes 0x555AAA555AAA555A to address 1; RF completes in the strobe cycle -> rf_write_en high one cycle, req0_done at T+2, req0_error=0.
REQ-036 req0 and req1 both assert reads at the same edge after reset -> req0 served first, req1 second; a repeated tie is then granted to req1.
REQ-037 req1 reads address 3; RF returns complete with invalid_address=1 -> req1_done=1 with req1_error=1.
REQ-038 Read with rf_access_complete held 0 and TIMEOUT=15 -> req0_done 15 cycles after the strobe, req0_error=1, read_data=0, timeout_count=1.
REQ-039 res_n driven low in ACCESS -> next cycle all outputs 0, no done pulse; a new request after release is served normally.
REQ-040 req0 drops valid one cycle after grant -> access still completes and req0_done pulses.
